// File: rtl/hazard_pkg.sv
// Shared types and helpers for the scoreboard hazard controller: forward-select
// codes, the per-stage instruction record and its match/aging helpers.
package hazard_pkg;

  // Record field widths; the top-level REG_AW/TIME_W parameters must equal these.
  localparam int HZ_REG_AW = 5;
  localparam int HZ_TIME_W = 2;

  localparam logic [1:0] FWD_D_RF  = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;
  localparam logic [1:0] FWD_D_W   = 2'd3;

  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;

  localparam logic       FWD_M_REG = 1'b0;
  localparam logic       FWD_M_W   = 1'b1;

  typedef struct packed {
    logic [HZ_REG_AW-1:0] a3;
    logic                 we;
    logic [HZ_TIME_W-1:0] tnew;
    logic [HZ_REG_AW-1:0] rs;
    logic [HZ_REG_AW-1:0] rt;
    logic [HZ_TIME_W-1:0] rs_tuse;
    logic [HZ_TIME_W-1:0] rt_tuse;
    logic                 md_start;
    logic                 md_div;
  } hz_rec_t;

  function automatic logic rec_match(input hz_rec_t rec, input logic [HZ_REG_AW-1:0] addr);
    return rec.we && (rec.a3 == addr) && (rec.a3 != '0);
  endfunction

  function automatic logic [HZ_TIME_W-1:0] dec_sat(input logic [HZ_TIME_W-1:0] t);
    return (t == '0) ? t : t - HZ_TIME_W'(1);
  endfunction

  // One stage of travel: every timing field moves one cycle closer to zero.
  function automatic hz_rec_t rec_age(input hz_rec_t rec);
    hz_rec_t r;
    r         = rec;
    r.tnew    = dec_sat(rec.tnew);
    r.rs_tuse = dec_sat(rec.rs_tuse);
    r.rt_tuse = dec_sat(rec.rt_tuse);
    return r;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Busy counter for the multi-cycle mult/div unit: loads when a mult/div sits in
// E at a clock edge, then counts down to idle.
module md_busy_counter #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_div,
  output logic o_busy
);

  localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is checked first so it beats a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/hazard_ctrl_sb.sv
// Scoreboard hazard controller for the 5-stage MIPS pipeline: tracks E/M/W
// destination records, selects D/E/M forwarding and raises the F/D stall.
module hazard_ctrl_sb #(
  parameter int REG_AW      = 5,
  parameter int TIME_W      = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs_addr,
  input  logic [REG_AW-1:0] D_rt_addr,
  input  logic [TIME_W-1:0] D_rs_tuse,
  input  logic [TIME_W-1:0] D_rt_tuse,
  input  logic [REG_AW-1:0] D_a3,
  input  logic              D_regwe,
  input  logic [TIME_W-1:0] D_tnew,
  input  logic              D_md_start,
  input  logic              D_md_div,
  input  logic              D_hilo_use,
  output logic [1:0]        D_rsop,
  output logic [1:0]        D_rtop,
  output logic [1:0]        E_rsop,
  output logic [1:0]        E_rtop,
  output logic              M_rtop,
  output logic              md_busy,
  output logic              stall
);

  import hazard_pkg::*;

  hz_rec_t r_rec_e, r_rec_m, r_rec_w;
  hz_rec_t w_rec_d;
  logic    w_md_busy, w_rs_stall, w_rt_stall, w_md_stall, w_stall;
  logic    w_unused;

  // A matching E record that is not ready hides older copies of the register.
  function automatic logic [1:0] d_fwd(input hz_rec_t e, input hz_rec_t m, input hz_rec_t w,
                                       input logic [REG_AW-1:0] addr);
    if (rec_match(e, addr)) return (e.tnew == '0) ? FWD_D_E : FWD_D_RF;
    if (rec_match(m, addr) && (m.tnew == '0)) return FWD_D_M;
    if (rec_match(w, addr)) return FWD_D_W;
    return FWD_D_RF;
  endfunction

  function automatic logic [1:0] e_fwd(input hz_rec_t m, input hz_rec_t w,
                                       input logic [REG_AW-1:0] addr);
    if (rec_match(m, addr) && (m.tnew == '0)) return FWD_E_M;
    if (rec_match(w, addr)) return FWD_E_W;
    return FWD_E_REG;
  endfunction

  function automatic logic reg_stall(input hz_rec_t e, input hz_rec_t m,
                                     input logic [REG_AW-1:0] addr, input logic [TIME_W-1:0] tuse);
    if (rec_match(e, addr)) return tuse < e.tnew;
    if (rec_match(m, addr)) return tuse < m.tnew;
    return 1'b0;
  endfunction

  assign w_rec_d = '{a3: D_a3, we: D_regwe, tnew: D_tnew, rs: D_rs_addr, rt: D_rt_addr,
                     rs_tuse: D_rs_tuse, rt_tuse: D_rt_tuse,
                     md_start: D_md_start, md_div: D_md_div};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rec_e <= '0;
      r_rec_m <= '0;
      r_rec_w <= '0;
    end else begin
      r_rec_w <= rec_age(r_rec_m);
      r_rec_m <= rec_age(r_rec_e);
      r_rec_e <= w_stall ? hz_rec_t'('0) : w_rec_d;
    end
  end

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_rec_e.md_start),
    .i_div  (r_rec_e.md_div),
    .o_busy (w_md_busy)
  );

  assign w_rs_stall = reg_stall(r_rec_e, r_rec_m, D_rs_addr, D_rs_tuse);
  assign w_rt_stall = reg_stall(r_rec_e, r_rec_m, D_rt_addr, D_rt_tuse);
  assign w_md_stall = D_hilo_use && (w_md_busy || r_rec_e.md_start);
  assign w_stall    = w_rs_stall | w_rt_stall | w_md_stall;

  assign D_rsop  = d_fwd(r_rec_e, r_rec_m, r_rec_w, D_rs_addr);
  assign D_rtop  = d_fwd(r_rec_e, r_rec_m, r_rec_w, D_rt_addr);
  assign E_rsop  = e_fwd(r_rec_m, r_rec_w, r_rec_e.rs);
  assign E_rtop  = e_fwd(r_rec_m, r_rec_w, r_rec_e.rt);
  assign M_rtop  = rec_match(r_rec_w, r_rec_m.rt) ? FWD_M_W : FWD_M_REG;
  assign md_busy = w_md_busy;
  assign stall   = w_stall;

  // The W record only feeds address matching; its timing fields retire here.
  assign w_unused = ^r_rec_w;

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Self-checking bench for hazard_ctrl_sb: an instruction-level pipeline model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_hazard_ctrl_sb;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs_addr, D_rt_addr, D_a3;
  logic [1:0] D_rs_tuse, D_rt_tuse, D_tnew;
  logic       D_regwe, D_md_start, D_md_div, D_hilo_use;
  logic [1:0] D_rsop, D_rtop, E_rsop, E_rtop;
  logic       M_rtop, md_busy, stall;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_sb #(
    .REG_AW(5), .TIME_W(2), .MULT_CYCLES(5), .DIV_CYCLES(10)
  ) dut (
    .clk(clk), .reset(reset),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
    .D_a3(D_a3), .D_regwe(D_regwe), .D_tnew(D_tnew),
    .D_md_start(D_md_start), .D_md_div(D_md_div), .D_hilo_use(D_hilo_use),
    .D_rsop(D_rsop), .D_rtop(D_rtop), .E_rsop(E_rsop), .E_rtop(E_rtop),
    .M_rtop(M_rtop), .md_busy(md_busy), .stall(stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each slot holds the instruction as issued from D; slot k is k stages past
  // E, so its remaining Tnew is the issued Tnew minus k, floored at zero.
  typedef struct {
    logic [4:0] a3;
    bit         we;
    int         tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         md;
    bit         dv;
  } m_instr_t;

  m_instr_t pipe [3];
  int       cyc      = 0;
  int       load_cyc = -1000;
  int       load_len = 0;
  bit       cmp_en   = 1'b0;

  function automatic m_instr_t m_bubble();
    m_instr_t b;
    b.a3 = 5'd0; b.we = 1'b0; b.tnew = 0; b.rs = 5'd0; b.rt = 5'd0; b.md = 1'b0; b.dv = 1'b0;
    return b;
  endfunction

  function automatic int eff(input int k);
    return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
  endfunction

  function automatic bit hit(input int k, input logic [4:0] a);
    return pipe[k].we && (pipe[k].a3 == a) && (a != 5'd0);
  endfunction

  function automatic int m_dop(input logic [4:0] a);
    if (hit(0, a)) return (eff(0) == 0) ? 1 : 0;
    if (hit(1, a) && eff(1) == 0) return 2;
    if (hit(2, a)) return 3;
    return 0;
  endfunction

  function automatic int m_eop(input logic [4:0] a);
    if (hit(1, a) && eff(1) == 0) return 1;
    if (hit(2, a)) return 2;
    return 0;
  endfunction

  function automatic bit m_rstall(input logic [4:0] a, input int tuse);
    if (hit(0, a)) return tuse < eff(0);
    if (hit(1, a)) return tuse < eff(1);
    return 1'b0;
  endfunction

  function automatic bit m_busy();
    return (cyc - load_cyc >= 0) && (cyc - load_cyc < load_len);
  endfunction

  function automatic bit m_stall();
    return m_rstall(D_rs_addr, int'(D_rs_tuse)) || m_rstall(D_rt_addr, int'(D_rt_tuse)) ||
           (D_hilo_use && (m_busy() || pipe[0].md));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) pipe[k] = m_bubble();
      load_cyc = -1000;
    end else begin
      bit s;
      m_instr_t d;
      s = m_stall();
      if (pipe[0].md) begin
        load_cyc = cyc + 1;
        load_len = pipe[0].dv ? 10 : 5;
      end
      d.a3 = D_a3; d.we = D_regwe; d.tnew = int'(D_tnew);
      d.rs = D_rs_addr; d.rt = D_rt_addr; d.md = D_md_start; d.dv = D_md_div;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = s ? m_bubble() : d;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("cmp_D_rsop",  D_rsop,  m_dop(D_rs_addr));
      check("cmp_D_rtop",  D_rtop,  m_dop(D_rt_addr));
      check("cmp_E_rsop",  E_rsop,  m_eop(pipe[0].rs));
      check("cmp_E_rtop",  E_rtop,  m_eop(pipe[0].rt));
      check("cmp_M_rtop",  M_rtop,  hit(2, pipe[1].rt));
      check("cmp_md_busy", md_busy, m_busy());
      check("cmp_stall",   stall,   m_stall());
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] rs, input int rs_t, input logic [4:0] rt, input int rt_t,
                       input logic [4:0] a3, input bit we, input int tnew,
                       input bit md, input bit dv, input bit hilo);
    D_rs_addr = rs;  D_rs_tuse = 2'(rs_t);
    D_rt_addr = rt;  D_rt_tuse = 2'(rt_t);
    D_a3 = a3; D_regwe = we; D_tnew = 2'(tnew);
    D_md_start = md; D_md_div = dv; D_hilo_use = hilo;
  endtask

  task automatic nop();
    drive(5'd0, 3, 5'd0, 3, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Holds an HI/LO reader in D after a mult/div entered E; counts busy and stall cycles.
  task automatic md_wait(input string tag, input int exp_busy, input int exp_stall);
    int busy_n = 0;
    int stall_n = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      sample();
      if (md_busy) busy_n++;
      if (stall) stall_n++;
      if (!md_busy) break;
    end
    check({tag, "_release_busy"},  md_busy, 0);
    check({tag, "_release_stall"}, stall, 0);
    check({tag, "_busy_cycles"},   busy_n, exp_busy);
    check({tag, "_stall_cycles"},  stall_n, exp_stall);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    cmp_en = 1'b1;
    sample();
    check("rst_D_rsop", D_rsop, 0);
    check("rst_E_rtop", E_rtop, 0);
    check("rst_M_rtop", M_rtop, 0);
    check("rst_stall",  stall, 0);
    check("rst_busy",   md_busy, 0);

    // Load-use: lw $8 (Tnew 2) then addu $10,$8,$9 with Tuse 1.
    step(); drive(5'd29, 1, 5'd0, 3, 5'd8, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    step(); drive(5'd8, 1, 5'd9, 1, 5'd10, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    sample(); check("load_stall", stall, 1);
    step();   sample(); check("load_stall_end", stall, 0);
    step(); nop();
    sample(); check("load_E_rsop_W", E_rsop, 2);

    // ALU result to a branch: addu $9 (Tnew 1) then beq $9 (Tuse 0).
    step(); drive(5'd0, 3, 5'd0, 3, 5'd9, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(); drive(5'd9, 0, 5'd0, 0, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    sample(); check("br_stall", stall, 1);
    step();   sample();
    check("br_stall_end", stall, 0);
    check("br_D_rsop_M", D_rsop, 2);

    // $5 written by both the E and the M record: E (ready) wins.
    step(); drive(5'd0, 3, 5'd0, 3, 5'd5, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(); drive(5'd0, 3, 5'd0, 3, 5'd5, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    step(); drive(5'd5, 1, 5'd5, 1, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    sample();
    check("dbl_D_rsop_E", D_rsop, 1);
    check("dbl_D_rtop_E", D_rtop, 1);
    check("dbl_stall", stall, 0);

    // $0 as destination is never a producer.
    step(); drive(5'd0, 3, 5'd0, 3, 5'd0, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(); drive(5'd0, 0, 5'd0, 0, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    sample();
    check("zero_D_rsop", D_rsop, 0);
    check("zero_stall", stall, 0);

    // E and M forwarding: $3 (Tnew 1), $4 uses $3, then a store of $4.
    step(); drive(5'd0, 3, 5'd0, 3, 5'd3, 1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(); drive(5'd3, 1, 5'd0, 3, 5'd4, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    sample();
    check("fwd_no_stall", stall, 0);
    check("fwd_D_rsop_blocked", D_rsop, 0);
    step(); drive(5'd0, 3, 5'd4, 2, 5'd0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    sample(); check("fwd_E_rsop_M", E_rsop, 1);
    step(); nop();
    sample(); check("fwd_E_rtop_M", E_rtop, 1);
    step(); sample(); check("fwd_M_rtop_W", M_rtop, 1);

    // div then mflo: one cycle on recE.md_start, then ten busy cycles.
    step(); drive(5'd2, 1, 5'd3, 1, 5'd0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    sample(); check("div_issue_stall", stall, 0);
    step(); drive(5'd0, 3, 5'd0, 3, 5'd12, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    sample();
    check("div_E_stall", stall, 1);
    check("div_E_busy", md_busy, 0);
    md_wait("div", 10, 11);

    // mult then mfhi: five busy cycles.
    step(); drive(5'd2, 1, 5'd3, 1, 5'd0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    step(); drive(5'd0, 3, 5'd0, 3, 5'd13, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    sample(); check("mult_E_stall", stall, 1);
    md_wait("mult", 5, 6);

    // Reset while a div has six cycles left.
    step(); drive(5'd2, 1, 5'd3, 1, 5'd0, 1'b0, 0, 1'b1, 1'b1, 1'b1);
    step(); nop();
    repeat (5) step();
    sample(); check("rstbusy_pre_busy", md_busy, 1);
    drive(5'd0, 3, 5'd0, 3, 5'd12, 1'b1, 1, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    check("rstbusy_busy",  md_busy, 0);
    check("rstbusy_stall", stall, 0);
    check("rstbusy_ops",   {D_rsop, D_rtop, E_rsop, E_rtop, M_rtop}, 0);

    step(); nop();
    repeat (3) step();
    sample();
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
